store_coalesce_buffer: RTL

// - Write-combining stage between the store buffer's commit-queue D$ port and the D$ store port.
// - Accepts committed, non-speculative stores and merges stores to the same XLEN-aligned word.
// - Drains merged words to the D$ in allocation (FIFO) order; cuts D$ store traffic for byte/half streams.
// - Store-to-different-word reordering is allowed (RVWMO); fences/AMOs use drain_i to force full drain.

---
 rtl/store_coalesce_buffer_pkg.sv | 55 +++++
 rtl/coalesce_byte_merge.sv | 23 ++
 rtl/store_coalesce_buffer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/store_coalesce_buffer_pkg.sv
// Shared types for the store coalescing stage: D$ request/response
// structs, the coalescing entry record and address helpers.
package store_coalesce_buffer_pkg;

  localparam int unsigned XLEN           = 64;
  localparam int unsigned PLEN           = 56;
  localparam int unsigned BE_W           = XLEN / 8;
  localparam int unsigned IDX_W          = 12;
  localparam int unsigned TAG_W          = PLEN - IDX_W;
  localparam int unsigned WADDR_W        = PLEN - 3;
  localparam int unsigned ID_W           = 2;
  localparam int unsigned DEPTH_COALESCE = 4;

  typedef enum logic [1:0] {
    SIZE_BYTE  = 2'b00,
    SIZE_HALF  = 2'b01,
    SIZE_WORD  = 2'b10,
    SIZE_DWORD = 2'b11
  } store_size_e;

  typedef struct packed {
    logic [IDX_W-1:0] address_index;
    logic [TAG_W-1:0] address_tag;
    logic [XLEN-1:0]  data_wdata;
    logic             data_req;
    logic             data_we;
    logic [BE_W-1:0]  data_be;
    logic [1:0]       data_size;
    logic [ID_W-1:0]  data_id;
    logic             kill_req;
    logic             tag_valid;
  } dcache_req_i_t;

  typedef struct packed {
    logic             data_gnt;
    logic             data_rvalid;
    logic [ID_W-1:0]  data_id;
    logic [XLEN-1:0]  data_rdata;
  } dcache_req_o_t;

  typedef struct packed {
    logic [WADDR_W-1:0] word_addr;
    logic [XLEN-1:0]    data;
    logic [BE_W-1:0]    be;
    logic [1:0]         size;
    logic               valid;
    logic               locked;
  } coalesce_entry_t;

  // XLEN-aligned word address carried by a D$ request
  function automatic logic [WADDR_W-1:0] req_word_addr(input dcache_req_i_t req);
    return {req.address_tag, req.address_index[IDX_W-1:3]};
  endfunction

endpackage

// File: rtl/coalesce_byte_merge.sv
// Byte-wise merge of a new store into an existing coalesced word.
module coalesce_byte_merge
  import store_coalesce_buffer_pkg::*;
(
  input  logic [XLEN-1:0] old_data,
  input  logic [BE_W-1:0] old_be,
  input  logic [XLEN-1:0] new_data,
  input  logic [BE_W-1:0] new_be,
  output logic [XLEN-1:0] data,
  output logic [BE_W-1:0] be,
  output logic            grew
);

  // new bytes win where enabled; grew flags bytes not previously covered
  always_comb begin
    for (int unsigned b = 0; b < BE_W; b++) begin
      data[b*8 +: 8] = new_be[b] ? new_data[b*8 +: 8] : old_data[b*8 +: 8];
    end
    be   = old_be | new_be;
    grew = |(new_be & ~old_be);
  end

endmodule

// File: rtl/store_coalesce_buffer.sv
// Write-combining FIFO between the committed-store port and the D$ store
// port. Stores to the same word merge into one unlocked entry; entries
// drain to the D$ in allocation order.
module store_coalesce_buffer
  import store_coalesce_buffer_pkg::*;
#(
  parameter int unsigned DEPTH   = DEPTH_COALESCE,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  dcache_req_i_t req_port_i,
  output dcache_req_o_t req_port_o,
  input  dcache_req_o_t dc_req_port_i,
  output dcache_req_i_t dc_req_port_o,
  input  logic          drain_i,
  input  logic [11:0]   page_offset_i,
  output logic          page_offset_matches_o,
  output logic          empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned AGE_W = $clog2(TIMEOUT + 1);

  coalesce_entry_t    entries [DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr, hit_idx;
  logic [CNT_W-1:0]   count;
  logic [AGE_W-1:0]   age;
  logic [WADDR_W-1:0] in_waddr;
  logic               hit, accept, alloc, issue, retire, off_match;
  coalesce_entry_t    head;
  logic [XLEN-1:0]    merge_data;
  logic [BE_W-1:0]    merge_be;
  logic               merge_grew;
  logic               unused_inputs;

  coalesce_byte_merge u_merge (
    .old_data (entries[hit_idx].data),
    .old_be   (entries[hit_idx].be),
    .new_data (req_port_i.data_wdata),
    .new_be   (req_port_i.data_be),
    .data     (merge_data),
    .be       (merge_be),
    .grew     (merge_grew)
  );

  // upstream accept: merge into the unlocked entry of the same word, else allocate
  always_comb begin
    in_waddr = req_word_addr(req_port_i);
    hit      = 1'b0;
    hit_idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (entries[i].valid && !entries[i].locked && entries[i].word_addr == in_waddr) begin
        hit     = 1'b1;
        hit_idx = PTR_W'(i);
      end
    end
    accept              = req_port_i.data_req && (hit || count < CNT_W'(DEPTH));
    alloc               = accept && !hit;
    req_port_o          = '0;
    req_port_o.data_gnt = accept;
  end

  // issue: decide when the head locks, drive the D$ port from a locked head
  always_comb begin
    off_match = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (entries[i].valid && entries[i].word_addr[8:0] == page_offset_i[11:3]) begin
        off_match = 1'b1;
      end
    end
    page_offset_matches_o = off_match ||
      (req_port_i.data_req && req_port_i.address_index[11:3] == page_offset_i[11:3]);
    head = entries[rd_ptr];
    // the lock lands one edge after the decision, so comparing against
    // TIMEOUT-1 puts the D$ request exactly TIMEOUT cycles after the head
    // became valid
    issue = head.valid && !head.locked &&
            (count == CNT_W'(DEPTH) || drain_i || off_match || age >= AGE_W'(TIMEOUT - 1));
    dc_req_port_o               = '0;
    dc_req_port_o.data_req      = head.valid && head.locked;
    dc_req_port_o.data_we       = 1'b1;
    dc_req_port_o.address_index = {head.word_addr[8:0], 3'b000};
    dc_req_port_o.address_tag   = head.word_addr[WADDR_W-1:9];
    dc_req_port_o.data_wdata    = head.data;
    dc_req_port_o.data_be       = head.be;
    dc_req_port_o.data_size     = head.size;
    retire  = head.valid && head.locked && dc_req_port_i.data_gnt;
    empty_o = (count == '0);
  end

  // fields of the upstream/D$ structs this stage does not consume
  always_comb begin
    unused_inputs = ^{req_port_i.data_we, req_port_i.data_id, req_port_i.kill_req,
                      req_port_i.tag_valid, req_port_i.address_index[2:0],
                      dc_req_port_i.data_rvalid, dc_req_port_i.data_id,
                      dc_req_port_i.data_rdata, page_offset_i[2:0]};
  end

  // entry array, pointers, occupancy and head age
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) entries[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      age    <= '0;
    end else begin
      if (retire) begin
        entries[rd_ptr].valid  <= 1'b0;
        entries[rd_ptr].locked <= 1'b0;
        rd_ptr                 <= rd_ptr + PTR_W'(1);
        age                    <= '0;
      end else if (head.valid && !head.locked && age < AGE_W'(TIMEOUT)) begin
        age <= age + AGE_W'(1);
      end
      if (issue) entries[rd_ptr].locked <= 1'b1;
      if (accept && hit) begin
        entries[hit_idx].data <= merge_data;
        entries[hit_idx].be   <= merge_be;
        if (merge_grew) entries[hit_idx].size <= SIZE_DWORD;
      end
      if (alloc) begin
        entries[wr_ptr] <= '{word_addr: in_waddr,
                             data:      req_port_i.data_wdata,
                             be:        req_port_i.data_be,
                             size:      req_port_i.data_size,
                             valid:     1'b1,
                             locked:    1'b0};
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(alloc) - CNT_W'(retire);
    end
  end

endmodule
